// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-FIFO round-robin scheduler feeding one UART transmitter.
// Optional macro UART_TX_ARB_PRIORITY_EN gives the keyboard FIFO strict priority.
module uart_tx_arbiter #(
   parameter int DEPTH     = 4,
   parameter int BUSY_WAIT = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] kb_data,
   input  logic       kb_valid,
   input  logic [7:0] sw_data,
   input  logic       sw_valid,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       kb_full,
   output logic       sw_full,
   output logic       grant_src,
   output logic [7:0] drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(BUSY_WAIT + 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   state_t        state;
   logic          last_src;
   logic [CW-1:0] wait_cnt;
   logic [1:0]    vld, ne, full, push, pop, drop;
   logic [7:0]    din [2];
   logic [7:0]    dout [2];
   logic          do_pop, pick_sw;
   logic [8:0]    drop_sum;

   assign vld      = {sw_valid, kb_valid};
   assign din[0]   = kb_data;
   assign din[1]   = sw_data;
   assign kb_full  = full[0];
   assign sw_full  = full[1];
   assign pop      = {do_pop & pick_sw, do_pop & ~pick_sw};
   assign drop_sum = 9'(drop_cnt) + 9'(drop[0]) + 9'(drop[1]);

   for (genvar g = 0; g < 2; g++) begin : g_fifo
      logic [7:0]  mem [DEPTH];
      logic [AW-1:0] wr, rd;
      logic [AW:0]   cnt;
      assign ne[g]   = cnt != '0;
      assign full[g] = cnt == (AW+1)'(DEPTH);
      assign push[g] = vld[g] & (~full[g] | pop[g]);
      assign drop[g] = vld[g] & ~push[g];
      assign dout[g] = mem[rd];
      // storage write; contents need no reset since occupancy guards reads
      always_ff @(posedge clk) begin
         if (push[g]) mem[wr] <= din[g];
      end
      // pointers wrap naturally at DEPTH; occupancy nets out simultaneous push and pop
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
         end else begin
            wr  <= wr + AW'(push[g]);
            rd  <= rd + AW'(pop[g]);
            cnt <= cnt + (AW+1)'(push[g]) - (AW+1)'(pop[g]);
         end
      end
   end

   // source selection: pop only when idle, something is queued and the UART is free
   always_comb begin
      do_pop = (state == IDLE) && !tx_busy && (ne != 2'b00);
`ifdef UART_TX_ARB_PRIORITY_EN
      pick_sw = !ne[0];
`else
      pick_sw = !ne[0] || (ne[1] && !last_src);
`endif
   end

   // one byte in flight: pop, pulse start, then follow busy or time out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tx_data   <= '0;
         tx_start  <= 1'b0;
         grant_src <= 1'b0;
         last_src  <= 1'b1;
         wait_cnt  <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            IDLE: if (do_pop) begin
               tx_data   <= pick_sw ? dout[1] : dout[0];
               grant_src <= pick_sw;
               last_src  <= pick_sw;
               tx_start  <= 1'b1;
               state     <= LAUNCH;
            end
            LAUNCH: begin
               wait_cnt <= '0;
               state    <= WAIT_BUSY;
            end
            WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
               else if (wait_cnt == CW'(BUSY_WAIT)) state <= IDLE;
               else wait_cnt <= wait_cnt + 1'b1;
            WAIT_DONE: if (!tx_busy) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // saturating drop counter; both requesters may drop in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt <= '0;
      else drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench with a simple UART busy model.
module tb_uart_tx_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] kb_data = '0, sw_data = '0;
   logic       kb_valid = 1'b0, sw_valid = 1'b0;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_start, kb_full, sw_full, grant_src;
   logic [7:0] drop_cnt;

   logic       force_busy = 1'b0, no_busy = 1'b0;
   int         left;
   int         cyc = 0;
   int         n_chk = 0, n_pass = 0;
   logic [7:0] q_data [$];
   int         q_cyc [$];

   uart_tx_arbiter dut (
      .clk(clk), .rst_n(rst_n), .kb_data(kb_data), .kb_valid(kb_valid),
      .sw_data(sw_data), .sw_valid(sw_valid), .tx_busy(tx_busy),
      .tx_data(tx_data), .tx_start(tx_start), .kb_full(kb_full),
      .sw_full(sw_full), .grant_src(grant_src), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign tx_busy = force_busy | (left != 0);

   // model UART: busy for 10 cycles after each start pulse unless disabled
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) left <= 0;
      else if (tx_start && !no_busy) left <= 10;
      else if (left != 0) left <= left - 1;
   end

   // record every start pulse away from the active edge
   always @(negedge clk) begin
      if (tx_start) begin
         q_data.push_back(tx_data);
         q_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      kb_valid = 1'b0;
      sw_valid = 1'b0;
      force_busy = 1'b0;
      no_busy = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      q_data.delete();
      q_cyc.delete();
   endtask

   task automatic push(input logic kv, input logic [7:0] kd, input logic sv, input logic [7:0] sd);
      kb_valid = kv;
      kb_data  = kd;
      sw_valid = sv;
      sw_data  = sd;
      @(negedge clk);
      kb_valid = 1'b0;
      sw_valid = 1'b0;
   endtask

   task automatic check_bytes(input string tag, input int n,
                              input logic [7:0] e0, e1, e2, e3, e4);
      logic [7:0] e [5];
      e = '{e0, e1, e2, e3, e4};
      check({tag, "_count"}, q_data.size(), n);
      for (int i = 0; i < n; i++)
         check($sformatf("%s[%0d]", tag, i), (i < q_data.size()) ? 32'(q_data[i]) : 32'hDEAD, e[i]);
   endtask

   initial begin
      // reset values and single sw byte latency
      do_reset;
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_grant", grant_src, 0);
      check("rst_kb_full", kb_full, 0);
      check("rst_sw_full", sw_full, 0);
      check("rst_drop", drop_cnt, 0);
      push(0, 8'h00, 1, 8'h41);
      check("t1_start_early", tx_start, 0);
      @(negedge clk);
      check("t1_start", tx_start, 1);
      check("t1_data", tx_data, 8'h41);
      check("t1_grant", grant_src, 1);
      repeat (30) @(negedge clk);
      check("t1_pulses", q_data.size(), 1);
      check("t1_data_hold", tx_data, 8'h41);

      // interleaving of two simultaneous requesters
      do_reset;
      push(1, 8'h1C, 1, 8'hA0);
      push(1, 8'h32, 1, 8'hA1);
      repeat (80) @(negedge clk);
`ifdef UART_TX_ARB_PRIORITY_EN
      check_bytes("t2_order", 4, 8'h1C, 8'h32, 8'hA0, 8'hA1, 8'h00);
`else
      check_bytes("t2_order", 4, 8'h1C, 8'hA0, 8'h32, 8'hA1, 8'h00);
`endif

      // overflow of the kb FIFO while the UART is busy
      do_reset;
      for (int i = 0; i < 6; i++) push(1, 8'(8'h10 + i), 0, 8'h00);
      check("t3_kb_full", kb_full, 1);
      check("t3_drop", drop_cnt, 1);
      repeat (100) @(negedge clk);
      check_bytes("t3_order", 5, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14);
      check("t3_drop_end", drop_cnt, 1);
      check("t3_kb_empty", kb_full, 0);

      // lost busy handshake: timeout spacing
      do_reset;
      no_busy = 1'b1;
      for (int i = 0; i < 3; i++) push(1, 8'(8'h21 + i), 0, 8'h00);
      repeat (40) @(negedge clk);
      check_bytes("t4_order", 3, 8'h21, 8'h22, 8'h23, 8'h00, 8'h00);
      check("t4_gap1", (q_cyc.size() > 1) ? q_cyc[1] - q_cyc[0] : -1, 6);
      check("t4_gap2", (q_cyc.size() > 2) ? q_cyc[2] - q_cyc[1] : -1, 6);

      // push and pop on a full FIFO in the same cycle
      do_reset;
      force_busy = 1'b1;
      for (int i = 0; i < 4; i++) push(1, 8'(8'h30 + i), 0, 8'h00);
      check("t5_full_before", kb_full, 1);
      check("t5_no_start", q_data.size(), 0);
      force_busy = 1'b0;
      push(1, 8'h34, 0, 8'h00);
      check("t5_full_after", kb_full, 1);
      check("t5_drop", drop_cnt, 0);
      check("t5_start", tx_start, 1);
      check("t5_data", tx_data, 8'h30);
      repeat (100) @(negedge clk);
      check_bytes("t5_order", 5, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34);
      check("t5_drop_end", drop_cnt, 0);

      // reset in the middle of a transfer with bytes queued
      do_reset;
      for (int i = 0; i < 3; i++) push(1, 8'(8'h40 + i), 0, 8'h00);
      repeat (3) @(negedge clk);
      check("t6_busy", tx_busy, 1);
      check("t6_data_pre", tx_data, 8'h40);
      rst_n = 1'b0;
      #1;
      check("t6_rst_data", tx_data, 0);
      check("t6_rst_start", tx_start, 0);
      check("t6_rst_grant", grant_src, 0);
      check("t6_rst_kb_full", kb_full, 0);
      check("t6_rst_drop", drop_cnt, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      q_data.delete();
      q_cyc.delete();
      repeat (30) @(negedge clk);
      check("t6_quiet", q_data.size(), 0);
      push(1, 8'h55, 0, 8'h00);
      repeat (3) @(negedge clk);
      check_bytes("t6_new", 1, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00);

      // double drops and saturation of drop_cnt
      do_reset;
      force_busy = 1'b1;
      for (int i = 0; i < 5; i++) push(1, 8'(i), 1, 8'(i));
      check("t7_drop2", drop_cnt, 2);
      check("t7_sw_full", sw_full, 1);
      for (int i = 0; i < 126; i++) push(1, 8'(i), 1, 8'(i));
      check("t7_drop254", drop_cnt, 254);
      push(1, 8'h00, 1, 8'h00);
      check("t7_drop_sat", drop_cnt, 255);
      push(1, 8'h00, 0, 8'h00);
      check("t7_drop_hold", drop_cnt, 255);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte producers: the PS/2 keyboard path (requester 0) and the switch/button path (requester 1).
- Each requester has its own FIFO. A round-robin scheduler pops one byte at a time.
- The scheduler drives the UART start pulse and data, and follows the UART busy handshake until the byte has fully left.
- Sits between the keyboard/switch front-end logic and the uart instance, replacing direct drive of the UART send-enable.

Parameters:
- DEPTH, 4, entries per requester FIFO; power of two, at least 2.
- BUSY_WAIT, 3, maximum cycles to wait for tx_busy to rise after a start pulse before the byte is treated as sent.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- kb_data  in  8  keyboard byte.
- kb_valid  in  1  one-cycle push strobe for kb_data.
- sw_data  in  8  switch byte.
- sw_valid  in  1  one-cycle push strobe for sw_data.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  8  byte presented to the UART.
- tx_start  out  1  one-cycle UART send-enable pulse.
- kb_full  out  1  keyboard FIFO full.
- sw_full  out  1  switch FIFO full.
- grant_src  out  1  source of the byte in flight: 0 = kb, 1 = sw.
- drop_cnt  out  8  saturating count of pushes rejected because the FIFO was full.

Behaviour:
- Reset (async, rst_n=0):
  - Both FIFOs empty; FSM in IDLE.
  - tx_data=0, tx_start=0, grant_src=0, last_src=1 (so kb wins the first tie), drop_cnt=0.
  - kb_full=0, sw_full=0.
  - Reset asserted mid-transfer aborts it. No tx_start is issued after release until a new byte is pushed.
- FIFOs:
  - Push on a valid strobe.
  - Push while full is dropped and increments drop_cnt, which saturates at 255. A kb drop and an sw drop in the same cycle add 2, still saturating.
  - Push and pop on the same FIFO in the same cycle is always accepted, even when full. Occupancy is unchanged.
  - Pointers wrap modulo DEPTH. The full flag comes from an occupancy counter of width log2(DEPTH)+1.
- FSM:
  - IDLE:
    - If either FIFO is non-empty, select a source. With both non-empty, pick !last_src; otherwise pick the non-empty one.
    - Pop the selected FIFO and register its byte into tx_data. Set grant_src and last_src. Go to LAUNCH.
    - Latency: a push into an empty system while in IDLE gives tx_start 2 cycles after the valid strobe.
  - LAUNCH: tx_start=1 for exactly one cycle; tx_data is stable. Go to WAIT_BUSY and clear the wait counter.
  - WAIT_BUSY:
    - If tx_busy=1, go to WAIT_DONE.
    - Otherwise increment the counter. When it reaches BUSY_WAIT, return to IDLE; the byte counts as sent (lost-handshake recovery).
  - WAIT_DONE: stay while tx_busy=1; go to IDLE on tx_busy=0.
- tx_data holds its value from LAUNCH until the next pop. tx_start is never high outside LAUNCH.
- There is at most one byte in flight, and no tx_start while tx_busy=1. If tx_busy is already 1 in IDLE with a byte pending, IDLE stalls without popping until tx_busy=0.
- Round-robin fairness: with both FIFOs continuously non-empty, grants strictly alternate.

Optional Feature:
- UART_TX_ARB_PRIORITY_EN:
  - When defined, the keyboard FIFO has strict priority: kb is chosen whenever it is non-empty, and last_src is ignored.
  - When undefined, round-robin as described above.

Test Plan:
- Reset then a single push sw_data=0x41:
  - tx_start pulses 2 cycles later with tx_data=0x41, grant_src=1.
  - The model UART holds busy for 10 cycles; FSM returns to IDLE; no further tx_start.
- Push kb 0x1C,0x32 and sw 0xA0,0xA1 in the same cycles:
  - Byte order on tx_data is 0x1C, 0xA0, 0x32, 0xA1.
  - With UART_TX_ARB_PRIORITY_EN the order is 0x1C, 0x32, 0xA0, 0xA1.
- With the UART held busy, push 6 kb bytes (DEPTH=4):
  - After the first pop: kb_full=1 and drop_cnt=1.
  - Remaining bytes transmit in order; drop_cnt stays 1.
- Model UART never raises busy:
  - Each byte completes after BUSY_WAIT=3 cycles in WAIT_BUSY.
  - 3 queued bytes give 3 tx_start pulses spaced 6 cycles apart.
- Push on a full kb FIFO in the same cycle as its pop: accepted, occupancy stays 4, drop_cnt unchanged.
- Assert rst_n=0 during WAIT_DONE with 2 bytes queued:
  - All outputs return to reset values immediately.
  - After release, no tx_start occurs until a new push.
